// File: rtl/connect_arbiter_pkg.sv
// Shared constants for the connect arbiter: payload width and arbitration mode encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package connect_arbiter_pkg;

   localparam int PACKET_WIDTH = 32;

   localparam int ARB_FIXED = 0;   // highest-index requester wins
   localparam int ARB_RR    = 1;   // round-robin starting after the last winner

   // Source-index width: never narrower than one bit, even for tiny channel counts.
   function automatic int id_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/connect_arbiter_fifo.sv
// Purpose: small generic queue, DEPTH entries (power of two) of WIDTH bits, strict FIFO order.
// Latency: a write is visible at rd_dat the cycle after it is accepted; no write-to-read bypass.
// Backpressure: wr_rdy drops when full (a same-cycle read does not reopen it); rd_dat holds while rd_rdy low.
//
// Ports: core_clk, rst (async active-high), wr_vld/wr_rdy/wr_dat, rd_vld/rd_rdy/rd_dat.
module arb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             core_clk,
   input  logic             rst,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             wr_fire;
   logic             rd_fire;

   // Readiness depends only on the registered count, so no downstream ready reaches upstream.
   assign wr_rdy  = (count != FULL_COUNT);
   assign rd_vld  = (count != '0);
   assign wr_fire = wr_vld && wr_rdy;
   assign rd_fire = rd_vld && rd_rdy;

   // Empty queue presents zeros rather than stale storage.
   assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         if (wr_fire && !rd_fire) begin
            count <= count + 1'b1;
         end else if (rd_fire && !wr_fire) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage needs no reset: entries are only observable while counted.
   always_ff @(posedge core_clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_dat;
   end

endmodule

// File: rtl/connect_arbiter.sv
// Purpose: N-channel valid/ready arbiter (fixed or round-robin) feeding a small output queue tagged with source id.
// Latency: one cycle from acceptance to SEND_VALID; no input-to-output bypass.
// Backpressure: RECEIVE_READY drops while the queue is full or RST is high; SEND_DATA/SEND_ID hold until SEND_READY.
//
// Ports: CLK, RST (async active-high); RECEIVE_VALID/READY/DATA per channel (channel i at
// bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]); SEND_VALID/READY/DATA/ID for the queue head.
module connect_arbiter
   import connect_arbiter_pkg::*;
#(
   parameter int  DATA_WIDTH  = PACKET_WIDTH,
   parameter int  CONNECT_NUM = 3,
   parameter int  ARB_MODE    = ARB_FIXED,
   parameter int  FIFO_DEPTH  = 2,
   localparam int ID_WIDTH    = id_width(CONNECT_NUM)
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
   output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
   output logic                              SEND_VALID,
   input  logic                              SEND_READY,
   output logic [DATA_WIDTH-1:0]             SEND_DATA,
   output logic [ID_WIDTH-1:0]               SEND_ID
);

   logic [ID_WIDTH-1:0]            last_grant;
   logic [ID_WIDTH-1:0]            winner;
   logic                           found;
   logic                           accept;
   logic                           fifo_wr_rdy;
   logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_dat;
   logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_rd_dat;

   // Winner selection uses only request lines and registered state.
   always_comb begin : arbitrate
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      if (ARB_MODE == ARB_RR) begin
         // Search starts one past the last winner and wraps; first hit wins.
         for (int k = 1; k <= CONNECT_NUM; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= CONNECT_NUM) idx = idx - CONNECT_NUM;
            if (!found && RECEIVE_VALID[idx]) begin
               found  = 1'b1;
               winner = ID_WIDTH'(idx);
            end
         end
      end else begin
         // Later (higher) indices overwrite earlier ones.
         for (int i = 0; i < CONNECT_NUM; i++) begin
            if (RECEIVE_VALID[i]) begin
               found  = 1'b1;
               winner = ID_WIDTH'(i);
            end
         end
      end
   end

   // Grant is withheld during reset so nothing in flight is taken.
   assign accept = found && fifo_wr_rdy && !RST;

   always_comb begin
      RECEIVE_READY = '0;
      if (accept) RECEIVE_READY[winner] = 1'b1;
   end

   assign fifo_wr_dat = {winner, RECEIVE_DATA[DATA_WIDTH*int'(winner) +: DATA_WIDTH]};

   // Reset to the top index so channel 0 is first in round-robin order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant <= ID_WIDTH'(CONNECT_NUM - 1);
      end else if (accept) begin
         last_grant <= winner;
      end
   end

   arb_fifo #(
      .WIDTH (ID_WIDTH + DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .core_clk (CLK),
      .rst      (RST),
      .wr_vld   (accept),
      .wr_rdy   (fifo_wr_rdy),
      .wr_dat   (fifo_wr_dat),
      .rd_vld   (SEND_VALID),
      .rd_rdy   (SEND_READY),
      .rd_dat   (fifo_rd_dat)
   );

   assign {SEND_ID, SEND_DATA} = fifo_rd_dat;

endmodule
